if_prefetch_stage: RTL and testbench



---
 rtl/if_prefetch_stage.sv | 158 +++++++++++++++
 tb/tb_if_prefetch_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch: sequential fetch ahead of decode into an in-order FIFO; response -> head visible next cycle.
// Credits bound issue by FIFO space and MAX_OUTSTANDING; Freeze holds the head; a taken branch flushes and discards in-flight data.
module if_prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_vld,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_vld) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_vld)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_vld) - CW'(pop_vld);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_vld && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
endmodule

module if_prefetch_stage #(
  parameter int                    WORD_WIDTH      = 32,
  parameter int                    PC_STEP         = 1,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [WORD_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Freeze,
  input  logic                  Branch_Taken,
  input  logic [WORD_WIDTH-1:0] Branch_Address,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_resp_valid,
  input  logic [WORD_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic [WORD_WIDTH-1:0] PC_Stage_out
);
  localparam int IW = $clog2(MAX_OUTSTANDING+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = $clog2(2*FIFO_DEPTH+1);
  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(PC_STEP);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc_next;
    logic [WORD_WIDTH-1:0] instr;
  } entry_t;

  logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [IW-1:0]         inflight_q, inflight_d, discard_q, discard_d;
  logic [CW-1:0]         fifo_count;
  logic [SW-1:0]         credit_used;
  entry_t                push_dat, head_dat;
  logic                  req_accept, push_vld, pop_vld;

  // Live in-flight requests already own a FIFO slot; discarded ones do not.
  assign credit_used    = SW'(fifo_count) + SW'(inflight_q) - SW'(discard_q);
  assign imem_req_valid = rst && !Branch_Taken
                          && (inflight_q < IW'(MAX_OUTSTANDING))
                          && (credit_used < SW'(FIFO_DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;

  assign inst_valid   = (fifo_count != '0);
  assign instruction  = inst_valid ? head_dat.instr   : '0;
  assign PC_Stage_out = inst_valid ? head_dat.pc_next : '0;

  assign push_vld = imem_resp_valid && (discard_q == '0) && !Branch_Taken;
  assign pop_vld  = inst_valid && !Freeze && !Branch_Taken;
  assign push_dat = '{pc_next: resp_pc_q + STEP, instr: imem_resp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + IW'(req_accept) - IW'(imem_resp_valid);
    if (Branch_Taken) begin
      fetch_pc_d = Branch_Address;
      resp_pc_d  = Branch_Address;
      discard_d  = inflight_q - IW'(imem_resp_valid);
    end else begin
      if (req_accept) fetch_pc_d = fetch_pc_q + STEP;
      if (imem_resp_valid) begin
        if (discard_q != '0) discard_d = discard_q - IW'(1);
        else                 resp_pc_d = resp_pc_q + STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  if_prefetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (Branch_Taken),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .count    (fifo_count),
    .head_dat (head_dat)
  );
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized bench for if_prefetch_stage against a tagged-request memory and queue model.
module tb_if_prefetch_stage;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk, rst, Freeze, Branch_Taken;
  logic [31:0] Branch_Address, imem_addr, imem_resp_data, instruction, PC_Stage_out;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid, inst_valid;

  if_prefetch_stage #(
    .WORD_WIDTH(32), .PC_STEP(1), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .Freeze(Freeze), .Branch_Taken(Branch_Taken),
    .Branch_Address(Branch_Address), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .instruction(instruction), .PC_Stage_out(PC_Stage_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc_next; logic [31:0] instr; } ent_t;

  req_t        pending[$];   // memory: accepted requests, oldest first
  ent_t        mq[$];        // instructions the stage should be holding
  logic [31:0] m_fetch_pc;
  int          cyc, last_due;
  int          n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 2;
  endfunction

  // One clock: drive at negedge, check before posedge, update model at posedge.
  task automatic run_cycle(input bit frz, input bit br, input logic [31:0] tgt,
                           input bit rdy, input int lat);
    bit   resp, exp_req, exp_iv, accept, do_pop;
    int   live, due;
    req_t r;
    Freeze = frz; Branch_Taken = br; Branch_Address = tgt; imem_req_ready = rdy;
    resp = (pending.size() > 0) && (pending[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(pending[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (pending[i]) if (!pending[i].stale) live++;
    exp_iv  = (mq.size() > 0);
    exp_req = !br && (pending.size() < MAXO) && ((mq.size() + live) < DEPTH);
    check_eq("inst_valid", inst_valid, exp_iv);
    check_eq("instruction", instruction, exp_iv ? mq[0].instr : 32'h0);
    check_eq("pc_out", PC_Stage_out, exp_iv ? mq[0].pc_next : 32'h0);
    check_eq("req_valid", imem_req_valid, exp_req);
    if (exp_req) check_eq("req_addr", imem_addr, m_fetch_pc);
    accept = imem_req_valid && rdy;
    do_pop = exp_iv && !frz && !br;
    @(posedge clk);
    if (br) foreach (pending[i]) pending[i].stale = 1'b1;
    if (do_pop) void'(mq.pop_front());
    if (resp) begin
      r = pending.pop_front();
      if (!r.stale) mq.push_back('{pc_next: r.addr + 32'd1, instr: mem_word(r.addr)});
    end
    if (br) begin
      mq.delete();
      m_fetch_pc = tgt;
    end else if (accept) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pending.push_back('{addr: m_fetch_pc, due: due, stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd1;
    end
    check_eq("inflight_le_max", 32'(pending.size() <= MAXO), 32'd1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_iv"},  inst_valid,     32'h0);
    check_eq({tag, "_ins"}, instruction,    32'h0);
    check_eq({tag, "_pc"},  PC_Stage_out,   32'h0);
    check_eq({tag, "_req"}, imem_req_valid, 32'h0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    Freeze = 0; Branch_Taken = 0; Branch_Address = 0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = 0;
    #1;
    check_reset_outputs("rst");
    pending.delete(); mq.delete();
    m_fetch_pc = RPC;
    repeat (2) @(posedge clk);
    cyc += 2; last_due = cyc;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_first_addr", imem_addr, RPC);
    check_eq("rst_first_req", imem_req_valid, 32'h1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; last_due = 0;
    apply_reset();

    // Zero-wait streaming.
    repeat (20) run_cycle(0, 0, 0, 1, 1);

    // Long freeze: FIFO fills, issue stops, stream resumes intact.
    repeat (10) run_cycle(1, 0, 0, 1, 1);
    check_eq("frz_iv", inst_valid, 32'h1);
    check_eq("frz_req_stopped", imem_req_valid, 32'h0);
    repeat (10) run_cycle(0, 0, 0, 1, 1);

    // Three requests in flight at latency 3, then branch to 0x100.
    for (int i = 0; i < 10; i++) begin
      if (pending.size() == 3) break;
      run_cycle(0, 0, 0, 1, 3);
    end
    check_eq("lat3_inflight", pending.size(), 32'd3);
    run_cycle(0, 1, 32'h100, 1, 3);
    check_eq("br_next_iv", inst_valid, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) break;
      run_cycle(0, 0, 0, 1, 3);
    end
    check_eq("br_tgt_valid", inst_valid, 32'h1);
    check_eq("br_tgt_pc", PC_Stage_out, 32'h101);
    check_eq("br_tgt_ins", instruction, 32'h200);

    // Branch colliding with a response and a pop (latency 2 steady state).
    repeat (12) run_cycle(0, 0, 0, 1, 2);
    check_eq("pre_br_iv", inst_valid, 32'h1);
    run_cycle(0, 1, 32'h40, 1, 2);
    check_eq("br_resp_iv", inst_valid, 32'h0);
    repeat (12) run_cycle(0, 0, 0, 1, 2);

    // Back-to-back branches, last one wins.
    run_cycle(0, 1, 32'h500, 1, 1);
    run_cycle(0, 1, 32'h600, 1, 1);
    repeat (8) run_cycle(0, 0, 0, 1, 1);

    // Random traffic, including targets that wrap the address space.
    for (int i = 0; i < 8000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 4095));
      run_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3, tgt,
                $urandom_range(0, 9) < 7, $urandom_range(1, 4));
    end

    // Reset mid-stream with the FIFO full.
    repeat (12) run_cycle(1, 0, 0, 1, 1);
    check_eq("full_before_rst", inst_valid, 32'h1);
    apply_reset();
    repeat (20) run_cycle(0, 0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
